sw_input_encoder: RTL

Board-input front end for the xc7a100t learning designs: the input-side counterpart of the switch-to-LED decoders. Synchronises and debounces the raw slide switches, and priority-encodes the debounced vector into a 2-bit code with a valid flag. Each debounced change is issued as an event through a valid/ready handshake so downstream logic (LED decoders, counters, FSM exercises) sees clean, single-shot updates.

---
 rtl/sw_input_encoder_if.sv | 27 ++
 rtl/sw_input_encoder.sv | 108 ++++++++++
 2 files changed

// File: rtl/sw_input_encoder_if.sv
// Event channel carrying one debounced switch snapshot and its priority code.
// Latency: none, this is a bundle of wires.
// Backpressure: the consumer holds ev_ready low to keep an event pending.
interface sw_input_encoder_if #(
    parameter int WIDTH = 4
);
    logic             ev_valid;
    logic             ev_ready;
    logic [WIDTH-1:0] ev_stable;
    logic [1:0]       ev_code;

    // Producer side: the encoder issuing events.
    modport master (
        output ev_valid,
        output ev_stable,
        output ev_code,
        input  ev_ready
    );

    // Consumer side: whatever acknowledges the events.
    modport slave (
        input  ev_valid,
        input  ev_stable,
        input  ev_code,
        output ev_ready
    );
endinterface

// File: rtl/sw_input_encoder.sv
// Synchronise, debounce and priority-encode slide switches; issue each change as an event.
// Latency: 2 sync edges + DEBOUNCE_CYCLES edges from a held SW change to sw_stable/code/event.
// Backpressure: an unaccepted event is overwritten by a newer one and sets sticky overflow.
module sw_input_encoder #(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [WIDTH-1:0]     SW,
    output logic [WIDTH-1:0]     sw_stable,
    output logic [1:0]           code,
    output logic                 code_valid,
    sw_input_encoder_if.master   ev,
    output logic                 overflow
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0] sync1;
    logic [WIDTH-1:0] sync2;
    logic [CNT_W-1:0] cnt     [WIDTH];
    logic [CNT_W-1:0] cnt_nxt [WIDTH];
    logic [WIDTH-1:0] stable_nxt;
    logic             chg;

    // Highest set bit wins; an all-zero vector also encodes to 0.
    function automatic logic [1:0] enc4(input logic [3:0] v);
        logic [1:0] r;
        casez (v)
            4'b1???: r = 2'd3;
            4'b01??: r = 2'd2;
            4'b001?: r = 2'd1;
            default: r = 2'd0;
        endcase
        return r;
    endfunction

    // Two-flop synchroniser for the asynchronous switch levels.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= SW;
            sync2 <= sync1;
        end
    end

    // Per-bit debounce: a new level must persist for DEBOUNCE_CYCLES cycles;
    // any return to the stable level restarts that bit's count.
    always_comb begin
        stable_nxt = sw_stable;
        for (int i = 0; i < WIDTH; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != sw_stable[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    stable_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + CNT_W'(1);
                end
            end
        end
        chg = (stable_nxt != sw_stable);
    end

    // Debounce state, plus the encoder registered from the next stable value
    // so that code/code_valid move on the same edge as sw_stable.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= '0;
            end
            sw_stable  <= '0;
            code       <= '0;
            code_valid <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            sw_stable  <= stable_nxt;
            code       <= enc4(stable_nxt);
            code_valid <= |stable_nxt;
        end
    end

    // Event register: a change always loads the newest snapshot; overwriting an
    // event the consumer has not taken marks overflow, which only reset clears.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ev.ev_valid  <= 1'b0;
            ev.ev_stable <= '0;
            ev.ev_code   <= '0;
            overflow     <= 1'b0;
        end else if (chg) begin
            ev.ev_valid  <= 1'b1;
            ev.ev_stable <= stable_nxt;
            ev.ev_code   <= enc4(stable_nxt);
            if (ev.ev_valid && !ev.ev_ready) begin
                overflow <= 1'b1;
            end
        end else if (ev.ev_valid && ev.ev_ready) begin
            ev.ev_valid <= 1'b0;
        end
    end

endmodule
